// File: rtl/pdm_demod_pkg.sv
// Shared constants and helpers for the PDM microphone receiver and its CIC decimator.
package pdm_demod_pkg;

   localparam int unsigned CIC_ORDER = 3;
   localparam int unsigned WARMUP    = 3;

   function automatic int unsigned cic_width(input int unsigned log2_r);
      return CIC_ORDER * log2_r + 1;
   endfunction

   // Positive result: shift CIC output left; negative: shift right.
   function automatic int scale_shift(input int unsigned log2_r, input int unsigned out_w);
      return int'(out_w) - int'(CIC_ORDER * log2_r);
   endfunction

endpackage

// File: rtl/pdm_demod_if.sv
// PCM sample stream from the PDM receiver to its consumer.
interface pdm_demod_if #(
   parameter int unsigned OUT_W = 16
) ();

   logic [OUT_W-1:0] pcm;
   logic             pcm_valid;
   logic             pcm_ready;
   logic             overrun;

   modport master (output pcm, output pcm_valid, output overrun, input pcm_ready);
   modport slave  (input pcm, input pcm_valid, input overrun, output pcm_ready);

endinterface

// File: rtl/cic3_decimator.sv
// Third-order CIC decimator for a 1-bit stream, with unsigned scaling and saturation.
module cic3_decimator
   import pdm_demod_pkg::*;
#(
   parameter int unsigned LOG2_R = 4,
   parameter int unsigned OUT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             strobe_i,
   input  logic             x_i,
   output logic             y_valid_o,
   output logic [OUT_W-1:0] s_o
);

   localparam int unsigned CicW  = cic_width(LOG2_R);
   localparam int          Shift = scale_shift(LOG2_R, OUT_W);
   localparam int unsigned ShUp  = (Shift > 0) ? unsigned'(Shift) : 32'd0;
   localparam int unsigned ShDn  = (Shift < 0) ? unsigned'(-Shift) : 32'd0;
   localparam int unsigned WideW = CicW + OUT_W;
   localparam logic [LOG2_R-1:0] DecLast = '1;

   logic [CicW-1:0]   integ1_q, integ1_d, integ2_q, integ2_d, integ3_q, integ3_d;
   logic [CicW-1:0]   dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
   logic [CicW-1:0]   y_q, y_d;
   logic [CicW-1:0]   comb1, comb2, comb3;
   logic [LOG2_R-1:0] dec_cnt_q, dec_cnt_d;
   logic              dump_q, dump_d;
   logic              y_valid_q, y_valid_d;
   logic [WideW-1:0]  wide;

   // Integrators wrap modulo 2^CicW; the comb differences stay exact.
   always_comb begin
      integ1_d  = integ1_q;
      integ2_d  = integ2_q;
      integ3_d  = integ3_q;
      dec_cnt_d = dec_cnt_q;
      dump_d    = 1'b0;
      if (strobe_i) begin
         integ1_d  = integ1_q + CicW'(x_i);
         integ2_d  = integ2_q + integ1_d;
         integ3_d  = integ3_q + integ2_d;
         dec_cnt_d = dec_cnt_q + 1'b1;
         dump_d    = (dec_cnt_q == DecLast);
      end
   end

   always_comb begin
      comb1     = integ3_q - dly1_q;
      comb2     = comb1 - dly2_q;
      comb3     = comb2 - dly3_q;
      dly1_d    = dly1_q;
      dly2_d    = dly2_q;
      dly3_d    = dly3_q;
      y_d       = y_q;
      y_valid_d = dump_q;
      if (dump_q) begin
         dly1_d = integ3_q;
         dly2_d = comb1;
         dly3_d = comb2;
         y_d    = comb3;
      end
   end

   always_comb begin
      wide = ({{OUT_W{1'b0}}, y_q} << ShUp) >> ShDn;
      s_o  = (|wide[WideW-1:OUT_W]) ? '1 : wide[OUT_W-1:0];
   end

   assign y_valid_o = y_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         integ1_q  <= '0;
         integ2_q  <= '0;
         integ3_q  <= '0;
         dly1_q    <= '0;
         dly2_q    <= '0;
         dly3_q    <= '0;
         y_q       <= '0;
         dec_cnt_q <= '0;
         dump_q    <= 1'b0;
         y_valid_q <= 1'b0;
      end else begin
         integ1_q  <= integ1_d;
         integ2_q  <= integ2_d;
         integ3_q  <= integ3_d;
         dly1_q    <= dly1_d;
         dly2_q    <= dly2_d;
         dly3_q    <= dly3_d;
         y_q       <= y_d;
         dec_cnt_q <= dec_cnt_d;
         dump_q    <= dump_d;
         y_valid_q <= y_valid_d;
      end
   end

endmodule

// File: rtl/pdm_demod.sv
// PDM microphone receiver: clock generation, input sync, CIC decimation, single-entry output.
module pdm_demod
   import pdm_demod_pkg::*;
#(
   parameter int unsigned CLK_DIV = 8,
   parameter int unsigned LOG2_R  = 4,
   parameter int unsigned OUT_W   = 16
) (
   input  logic        clk,
   input  logic        rst,
   output logic        pdm_clk,
   input  logic        pdm_data,
   pdm_demod_if.master pcm_if
);

   localparam int unsigned DivW  = $clog2(CLK_DIV);
   localparam int unsigned WarmW = $clog2(WARMUP + 1);
   localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
   localparam logic [DivW-1:0]  DivHalf  = DivW'(CLK_DIV / 2);
   localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP);

   logic [DivW-1:0]  div_cnt_q, div_cnt_d;
   logic             pdm_clk_q, pdm_clk_d;
   logic [1:0]       sync_q, sync_d;
   logic [WarmW-1:0] warm_cnt_q, warm_cnt_d;
   logic [OUT_W-1:0] pcm_q, pcm_d;
   logic             pcm_valid_q, pcm_valid_d;
   logic             overrun_q, overrun_d;
   logic             strobe, y_valid, warm_done, load;
   logic [OUT_W-1:0] s;

   // Sample on the last high cycle, just before the microphone sees the falling edge.
   assign strobe    = (div_cnt_q == DivLast);
   assign warm_done = (warm_cnt_q == WarmLast);
   assign load      = y_valid && warm_done;

   cic3_decimator #(
      .LOG2_R (LOG2_R),
      .OUT_W  (OUT_W)
   ) u_cic (
      .clk       (clk),
      .rst       (rst),
      .strobe_i  (strobe),
      .x_i       (sync_q[1]),
      .y_valid_o (y_valid),
      .s_o       (s)
   );

   always_comb begin
      div_cnt_d   = (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;
      pdm_clk_d   = (div_cnt_d >= DivHalf);
      sync_d      = {sync_q[0], pdm_data};
      warm_cnt_d  = warm_cnt_q;
      pcm_d       = pcm_q;
      pcm_valid_d = pcm_valid_q;
      overrun_d   = 1'b0;
      if (y_valid && !warm_done) begin
         warm_cnt_d = warm_cnt_q + 1'b1;
      end
      if (load) begin
         pcm_d       = s;
         pcm_valid_d = 1'b1;
         overrun_d   = pcm_valid_q && !pcm_if.pcm_ready;
      end else if (pcm_valid_q && pcm_if.pcm_ready) begin
         pcm_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q   <= '0;
         pdm_clk_q   <= 1'b0;
         sync_q      <= '0;
         warm_cnt_q  <= '0;
         pcm_q       <= '0;
         pcm_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         pdm_clk_q   <= pdm_clk_d;
         sync_q      <= sync_d;
         warm_cnt_q  <= warm_cnt_d;
         pcm_q       <= pcm_d;
         pcm_valid_q <= pcm_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign pdm_clk          = pdm_clk_q;
   assign pcm_if.pcm       = pcm_q;
   assign pcm_if.pcm_valid = pcm_valid_q;
   assign pcm_if.overrun   = overrun_q;

endmodule
